// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: two 1-entry holding buffers (ALU, load) share the register file write port
// through a round-robin grant and a registered write stage; also exports a pending-write bitmap.
module rf_wb_arbiter #(
  parameter int DW           = 32,
  parameter int AW           = 5,
  parameter int ZERO_DISCARD = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [AW-1:0]       a_addr,
  input  logic [DW-1:0]       a_data,
  input  logic                m_valid,
  output logic                m_ready,
  input  logic [AW-1:0]       m_addr,
  input  logic [DW-1:0]       m_data,
  output logic                rg_wrt_en,
  output logic [AW-1:0]       rg_wrt_addr,
  output logic [DW-1:0]       rg_wrt_data,
  output logic [(1<<AW)-1:0]  pend_mask
);

  localparam int NREG = 1 << AW;

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_M = 1'b1
  } rrPtr_e;

  logic          holdValidA_q, holdValidA_d;
  logic [AW-1:0] holdAddrA_q,  holdAddrA_d;
  logic [DW-1:0] holdDataA_q,  holdDataA_d;
  logic          holdValidM_q, holdValidM_d;
  logic [AW-1:0] holdAddrM_q,  holdAddrM_d;
  logic [DW-1:0] holdDataM_q,  holdDataM_d;
  rrPtr_e        rrPtr_q,      rrPtr_d;
  logic          wrtEn_q,      wrtEn_d;
  logic [AW-1:0] wrtAddr_q,    wrtAddr_d;
  logic [DW-1:0] wrtData_q,    wrtData_d;

  logic          grantA;
  logic          grantM;
  logic          anyGrant;
  logic [AW-1:0] grantAddr;
  logic [DW-1:0] grantData;
  logic          grantIsZero;
  logic          acceptA;
  logic          acceptM;

  // Arbitration and ready are purely from registered state, so no valid->ready path exists.
  always_comb begin
    grantA    = holdValidA_q & (~holdValidM_q | (rrPtr_q == PTR_A));
    grantM    = holdValidM_q & (~holdValidA_q | (rrPtr_q == PTR_M));
    anyGrant  = grantA | grantM;
    grantAddr = grantA ? holdAddrA_q : holdAddrM_q;
    grantData = grantA ? holdDataA_q : holdDataM_q;
    a_ready   = ~holdValidA_q | grantA;
    m_ready   = ~holdValidM_q | grantM;
    acceptA   = a_valid & a_ready;
    acceptM   = m_valid & m_ready;
    grantIsZero = (ZERO_DISCARD != 0) && (grantAddr == '0);
  end

  always_comb begin
    holdValidA_d = holdValidA_q;
    holdAddrA_d  = holdAddrA_q;
    holdDataA_d  = holdDataA_q;
    holdValidM_d = holdValidM_q;
    holdAddrM_d  = holdAddrM_q;
    holdDataM_d  = holdDataM_q;
    rrPtr_d      = rrPtr_q;
    wrtEn_d      = anyGrant & ~grantIsZero;
    wrtAddr_d    = wrtAddr_q;
    wrtData_d    = wrtData_q;

    if (acceptA) begin
      holdValidA_d = 1'b1;
      holdAddrA_d  = a_addr;
      holdDataA_d  = a_data;
    end else if (grantA) begin
      holdValidA_d = 1'b0;
    end

    if (acceptM) begin
      holdValidM_d = 1'b1;
      holdAddrM_d  = m_addr;
      holdDataM_d  = m_data;
    end else if (grantM) begin
      holdValidM_d = 1'b0;
    end

    // The pointer only moves when both buffers competed, so a lone stream never disturbs fairness.
    if (holdValidA_q && holdValidM_q) begin
      rrPtr_d = grantA ? PTR_M : PTR_A;
    end

    if (anyGrant) begin
      wrtAddr_d = grantAddr;
      wrtData_d = grantData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      holdValidA_q <= 1'b0;
      holdAddrA_q  <= '0;
      holdDataA_q  <= '0;
      holdValidM_q <= 1'b0;
      holdAddrM_q  <= '0;
      holdDataM_q  <= '0;
      rrPtr_q      <= PTR_A;
      wrtEn_q      <= 1'b0;
      wrtAddr_q    <= '0;
      wrtData_q    <= '0;
    end else begin
      holdValidA_q <= holdValidA_d;
      holdAddrA_q  <= holdAddrA_d;
      holdDataA_q  <= holdDataA_d;
      holdValidM_q <= holdValidM_d;
      holdAddrM_q  <= holdAddrM_d;
      holdDataM_q  <= holdDataM_d;
      rrPtr_q      <= rrPtr_d;
      wrtEn_q      <= wrtEn_d;
      wrtAddr_q    <= wrtAddr_d;
      wrtData_q    <= wrtData_d;
    end
  end

  assign rg_wrt_en   = wrtEn_q;
  assign rg_wrt_addr = wrtAddr_q;
  assign rg_wrt_data = wrtData_q;

  // Register 0 is never really written when discarding, so decode must never stall on it.
  always_comb begin
    pend_mask = '0;
    if (holdValidA_q) pend_mask[holdAddrA_q] = 1'b1;
    if (holdValidM_q) pend_mask[holdAddrM_q] = 1'b1;
    if (wrtEn_q)      pend_mask[wrtAddr_q]   = 1'b1;
    if (ZERO_DISCARD != 0) pend_mask[0] = 1'b0;
  end

  logic unusedNreg;
  assign unusedNreg = (NREG == 0);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter: reset, lone stream, contention,
// address-0 discard, pending mask lifetime and reset mid-flight.
module tb_rf_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          reset;
  logic          a_valid, a_ready;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          m_valid, m_ready;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          rg_wrt_en;
  logic [AW-1:0] rg_wrt_addr;
  logic [DW-1:0] rg_wrt_data;
  logic [31:0]   pend_mask;

  int vectorCount = 0;
  int missCount   = 0;

  rf_wb_arbiter #(.DW(DW), .AW(AW), .ZERO_DISCARD(1)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
    .rg_wrt_en(rg_wrt_en), .rg_wrt_addr(rg_wrt_addr), .rg_wrt_data(rg_wrt_data),
    .pend_mask(pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                               input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    a_valid = av; a_addr = aa; a_data = ad;
    m_valid = mv; m_addr = ma; m_data = md;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    assert (observed === expected)
    else begin
      missCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b1, 5'd3, 32'h3333, 1'b1, 5'd4, 32'h4444);

    // reset held two cycles with both requesters valid
    tick();
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("rst_en",    {31'd0, rg_wrt_en}, 32'd0);
    checkOutput("rst_pend",  pend_mask, 32'd0);
    checkOutput("rst_aRdy",  {31'd0, a_ready}, 32'd1);
    checkOutput("rst_mRdy",  {31'd0, m_ready}, 32'd1);
    checkOutput("rst_addr",  {27'd0, rg_wrt_addr}, 32'd0);
    checkOutput("rst_data",  rg_wrt_data, 32'd0);
    tick();
    checkOutput("rst_en2",   {31'd0, rg_wrt_en}, 32'd0);

    // lone stream r1..r4 from A
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) applyStimulus(1'b1, AW'(i), 32'(i) * 32'h11, 1'b0, '0, '0);
      else        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      checkOutput("lone_aRdy", {31'd0, a_ready}, 32'd1);
      tick();
      if (i == 1) begin
        checkOutput("lone_en_first", {31'd0, rg_wrt_en}, 32'd0);
        checkOutput("lone_pend1", pend_mask, 32'h0000_0002);
      end else begin
        checkOutput("lone_en",   {31'd0, rg_wrt_en}, 32'd1);
        checkOutput("lone_addr", {27'd0, rg_wrt_addr}, 32'(i - 1));
        checkOutput("lone_data", rg_wrt_data, 32'(i - 1) * 32'h11);
      end
      if (i == 2) checkOutput("lone_pend2", pend_mask, 32'h0000_0006);
    end
    tick();
    checkOutput("lone_en_end", {31'd0, rg_wrt_en}, 32'd0);
    checkOutput("lone_pend_end", pend_mask, 32'd0);

    // first contention: pointer at A after reset
    applyStimulus(1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd6, 32'hBBBB);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("con1_aRdy", {31'd0, a_ready}, 32'd1);
    checkOutput("con1_mRdy", {31'd0, m_ready}, 32'd0);
    checkOutput("con1_pend", pend_mask, 32'h0000_0060);
    tick();
    checkOutput("con1_en1",   {31'd0, rg_wrt_en}, 32'd1);
    checkOutput("con1_addr1", {27'd0, rg_wrt_addr}, 32'd5);
    checkOutput("con1_data1", rg_wrt_data, 32'hAAAA);
    tick();
    checkOutput("con1_en2",   {31'd0, rg_wrt_en}, 32'd1);
    checkOutput("con1_addr2", {27'd0, rg_wrt_addr}, 32'd6);
    checkOutput("con1_data2", rg_wrt_data, 32'hBBBB);
    tick();
    checkOutput("con1_idle",  {31'd0, rg_wrt_en}, 32'd0);

    // second contention: pointer moved to M
    applyStimulus(1'b1, 5'd11, 32'h1111, 1'b1, 5'd12, 32'h2222);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("con2_aRdy", {31'd0, a_ready}, 32'd0);
    checkOutput("con2_mRdy", {31'd0, m_ready}, 32'd1);
    tick();
    checkOutput("con2_addr1", {27'd0, rg_wrt_addr}, 32'd12);
    checkOutput("con2_data1", rg_wrt_data, 32'h2222);
    tick();
    checkOutput("con2_addr2", {27'd0, rg_wrt_addr}, 32'd11);
    checkOutput("con2_data2", rg_wrt_data, 32'h1111);
    tick();

    // address-0 write is consumed but never issued
    applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b0, '0, '0);
    checkOutput("zd_aRdy0", {31'd0, a_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("zd_pend0", pend_mask, 32'd0);
    checkOutput("zd_aRdy1", {31'd0, a_ready}, 32'd1);
    tick();
    checkOutput("zd_en1",   {31'd0, rg_wrt_en}, 32'd0);
    checkOutput("zd_data",  rg_wrt_data, 32'hDEAD);
    checkOutput("zd_pend1", pend_mask, 32'd0);
    tick();
    checkOutput("zd_en2",   {31'd0, rg_wrt_en}, 32'd0);

    // pending bit lifetime for M r7
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 32'h77);
    checkOutput("pm_before", pend_mask, 32'd0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("pm_held",  pend_mask, 32'h0000_0080);
    tick();
    checkOutput("pm_staged", pend_mask, 32'h0000_0080);
    checkOutput("pm_en",    {31'd0, rg_wrt_en}, 32'd1);
    checkOutput("pm_addr",  {27'd0, rg_wrt_addr}, 32'd7);
    tick();
    checkOutput("pm_en_off", {31'd0, rg_wrt_en}, 32'd0);
    checkOutput("pm_clear", pend_mask, 32'd0);

    // reset right after both requests are buffered
    applyStimulus(1'b1, 5'd9, 32'h9999, 1'b1, 5'd10, 32'hA0A0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("rmf_pend", pend_mask, 32'h0000_0600);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rmf_en0",   {31'd0, rg_wrt_en}, 32'd0);
    checkOutput("rmf_pend0", pend_mask, 32'd0);
    checkOutput("rmf_addr0", {27'd0, rg_wrt_addr}, 32'd0);
    tick();
    checkOutput("rmf_en1",   {31'd0, rg_wrt_en}, 32'd0);
    checkOutput("rmf_pend1", pend_mask, 32'd0);
    checkOutput("rmf_aRdy",  {31'd0, a_ready}, 32'd1);
    checkOutput("rmf_mRdy",  {31'd0, m_ready}, 32'd1);
    tick();
    checkOutput("rmf_en2",   {31'd0, rg_wrt_en}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
